// File: rtl/alu_pkg.sv
// Shared ALU constants, widths, arbiter FSM state type and flag positions.
// Imported by the ALU share arbiter and its round-robin sub-block.
package alu_pkg;

  localparam int DW   = 64;
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_AND = 3'd2;
  localparam logic [OPW-1:0] OP_OR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_MUL = 3'd5;
  localparam logic [OPW-1:0] OP_DIV = 3'd6;
  localparam logic [OPW-1:0] OP_RSV = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam int FL_ZERO = 0;
  localparam int FL_COUT = 1;
  localparam int FL_OVF  = 2;
  localparam int FL_DIV0 = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time wins ties.
// Ports: valid[1:0], last_gnt in; any (someone valid), idx (granted index) out.
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_gnt,
  output logic       any,
  output logic       idx
);

  always_comb begin
    any = |valid;
    idx = 1'b0;
    if (&valid) begin
      idx = ~last_gnt;
    end else begin
      idx = valid[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters, registered in/out.
// Ports: req0/req1 valid-ready channels, alu_* to/from ALU, tagged resp channel, perf counters.
// Optional: define ALU_ARB_PERF_EN to enable saturating per-requester grant counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DW   = alu_pkg::DW,
  parameter int OPW  = alu_pkg::OPW,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_op,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_op,
  input  logic [TAGW-1:0] req1_tag,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   alu_y,
  input  logic [DW-1:0]   alu_y_hi,
  input  logic [DW-1:0]   alu_rem,
  input  logic            alu_zero,
  input  logic            alu_cout,
  input  logic            alu_ovf,
  input  logic            alu_div0,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [TAGW-1:0] resp_tag,
  output logic [DW-1:0]   resp_y,
  output logic [DW-1:0]   resp_y_hi,
  output logic [DW-1:0]   resp_rem,
  output logic [3:0]      resp_flags,
  output logic [31:0]     perf_cnt0,
  output logic [31:0]     perf_cnt1
);

  state_t          state_q, state_d;
  logic            last_q;
  logic            any, idx, hs;
  logic [DW-1:0]   a_q, b_q;
  logic [OPW-1:0]  op_q;
  logic [TAGW-1:0] tag_q;
  logic            id_q;
  logic [DW-1:0]   y_q, hi_q, rem_q;
  logic [3:0]      fl_q;

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (last_q),
    .any      (any),
    .idx      (idx)
  );

  // Ready is masked by rst so it reads 0 while reset is held.
  assign hs         = (state_q == IDLE) && any && !rst;
  assign req0_ready = hs && !idx;
  assign req1_ready = hs && idx;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      id_q    <= 1'b0;
      y_q     <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        last_q <= idx;
        id_q   <= idx;
        a_q    <= idx ? req1_a   : req0_a;
        b_q    <= idx ? req1_b   : req0_b;
        op_q   <= idx ? req1_op  : req0_op;
        tag_q  <= idx ? req1_tag : req0_tag;
      end
      if (state_q == EXEC) begin
        y_q           <= alu_y;
        hi_q          <= alu_y_hi;
        rem_q         <= alu_rem;
        fl_q[FL_ZERO] <= alu_zero;
        fl_q[FL_COUT] <= alu_cout;
        fl_q[FL_OVF]  <= alu_ovf;
        fl_q[FL_DIV0] <= alu_div0;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_tag   = tag_q;
  assign resp_y     = y_q;
  assign resp_y_hi  = hi_q;
  assign resp_rem   = rem_q;
  assign resp_flags = fl_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && (cnt0_q != 32'hFFFF_FFFF)) cnt0_q <= cnt0_q + 32'd1;
      if (req1_ready && (cnt1_q != 32'hFFFF_FFFF)) cnt1_q <= cnt1_q + 32'd1;
    end
  end

  assign perf_cnt0 = cnt0_q;
  assign perf_cnt1 = cnt1_q;
`else
  assign perf_cnt0 = '0;
  assign perf_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, transaction-level model,
// directed cases plus randomized traffic.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [3:0]  req0_tag, req1_tag;
  logic [63:0] alu_a, alu_b, alu_y, alu_y_hi, alu_rem;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_cout, alu_ovf, alu_div0;
  logic        resp_valid, resp_ready, resp_id;
  logic [3:0]  resp_tag, resp_flags;
  logic [63:0] resp_y, resp_y_hi, resp_rem;
  logic [31:0] perf_cnt0, perf_cnt1;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_y_hi(alu_y_hi), .alu_rem(alu_rem),
    .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_div0(alu_div0),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_y(resp_y), .resp_y_hi(resp_y_hi),
    .resp_rem(resp_rem), .resp_flags(resp_flags),
    .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
  );

  function automatic void alu_fn(
    input  logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
    output logic [63:0] y, output logic [63:0] hi, output logic [63:0] rem,
    output logic [3:0] fl);
    logic [64:0]  s;
    logic [127:0] p;
    logic c, v, d0;
    y = '0; hi = '0; rem = '0; c = 0; v = 0; d0 = 0;
    s = '0; p = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[63:0]; c = s[64];
        v = (a[63] == b[63]) && (y[63] != a[63]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b};
        y = s[63:0]; c = s[64];
        v = (a[63] != b[63]) && (y[63] != a[63]);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin
        p = {64'd0, a} * {64'd0, b};
        y = p[63:0]; hi = p[127:64];
      end
      3'd6: begin
        if (b == 0) begin
          y = '1; rem = a; d0 = 1;
        end else begin
          y = a / b; rem = a % b;
        end
      end
      default: y = '0;
    endcase
    fl = {d0, v, c, (y == 0)};
  endfunction

  always_comb begin
    logic [3:0] f;
    f = '0;
    alu_fn(alu_a, alu_b, alu_op, alu_y, alu_y_hi, alu_rem, f);
    alu_zero = f[0];
    alu_cout = f[1];
    alu_ovf  = f[2];
    alu_div0 = f[3];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one op in flight, response due two cycles
  // after acceptance, new acceptance only after the response is taken.
  int          cyc = 0;
  bit          pend, mlast;
  int          resp_at;
  int          mcnt[2];
  logic        e_id;
  logic [3:0]  e_tag, e_fl;
  logic [63:0] e_y, e_hi, e_rem;
  bit          hs_done, rsp_done;
  logic        lr_id;
  logic [3:0]  lr_tag, lr_fl;
  logic [63:0] lr_y, lr_hi, lr_rem;

  task automatic model_reset();
    pend = 0; mlast = 1; mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic step();
    bit v0, v1, acc, g, e_rv;
    logic [63:0] a, b;
    logic [2:0]  op;
    logic [3:0]  tg;
    #1;
    v0 = req0_valid; v1 = req1_valid;
    acc = !pend && (v0 || v1);
    g = (v0 && v1) ? !mlast : v1;
    e_rv = pend && (cyc >= resp_at);
    check("req0_ready", req0_ready, acc && !g);
    check("req1_ready", req1_ready, acc && g);
    check("resp_valid", resp_valid, e_rv);
    if (e_rv) begin
      check("resp_id", resp_id, e_id);
      check("resp_tag", resp_tag, e_tag);
      check("resp_y", resp_y, e_y);
      check("resp_y_hi", resp_y_hi, e_hi);
      check("resp_rem", resp_rem, e_rem);
      check("resp_flags", resp_flags, e_fl);
    end
    a  = g ? req1_a : req0_a;
    b  = g ? req1_b : req0_b;
    op = g ? req1_op : req0_op;
    tg = g ? req1_tag : req0_tag;
    hs_done = 0; rsp_done = 0;
    if (e_rv && resp_ready) begin
      rsp_done = 1;
      lr_id = resp_id; lr_tag = resp_tag; lr_fl = resp_flags;
      lr_y = resp_y; lr_hi = resp_y_hi; lr_rem = resp_rem;
    end
    @(posedge clk);
    if (rsp_done) pend = 0;
    if (acc) begin
      hs_done = 1; pend = 1; resp_at = cyc + 2; mlast = g;
      mcnt[g]++;
      e_id = g; e_tag = tg;
      alu_fn(a, b, op, e_y, e_hi, e_rem, e_fl);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] op,
                         input logic [3:0] tg);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_tag = tg;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_tag = tg;
    end
  endtask

  task automatic issue(input int n, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] op, input logic [3:0] tg);
    int k;
    resp_ready = 1;
    set_req(n, 1, a, b, op, tg);
    k = 0;
    do begin step(); k++; end while (!hs_done && k < 10);
    if (!hs_done) check("accept_timeout", 1, 0);
    set_req(n, 0, a, b, op, tg);
    k = 0;
    do begin step(); k++; end while (!rsp_done && k < 10);
    if (!rsp_done) check("resp_timeout", 1, 0);
  endtask

  task automatic drain();
    int k;
    resp_ready = 1;
    k = 0;
    while (pend && k < 20) begin step(); k++; end
    if (pend) check("drain_timeout", 1, 0);
  endtask

  initial begin
    logic ids[$];
    int   k;
    rst = 1; resp_ready = 0;
    set_req(0, 1, 64'd1, 64'd1, 3'd0, 4'd0);
    set_req(1, 1, 64'd2, 64'd2, 3'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_y", resp_y, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_perf0", perf_cnt0, 0);
    rst = 0;
    model_reset();

    // Both requesters valid continuously: grants alternate starting at 0.
    resp_ready = 1;
    set_req(0, 1, 64'd10, 64'd3, 3'd1, 4'd4);
    set_req(1, 1, 64'd20, 64'd5, 3'd0, 4'd8);
    repeat (13) begin
      step();
      if (rsp_done) ids.push_back(lr_id);
    end
    check("alt_count", ids.size(), 4);
    for (int i = 0; i < 4 && i < ids.size(); i++)
      check($sformatf("alt_id%0d", i), ids[i], i % 2);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    drain();

    issue(0, 64'd5, 64'd7, 3'd0, 4'd3);
    check("add_y", lr_y, 12);
    check("add_id", lr_id, 0);
    check("add_tag", lr_tag, 3);
    check("add_fl", lr_fl, 4'b0000);

    issue(1, 64'h8000_0000_0000_0000, 64'd2, 3'd5, 4'd9);
    check("mul_y", lr_y, 0);
    check("mul_hi", lr_hi, 1);
    check("mul_fl", lr_fl, 4'b0001);
    check("mul_id", lr_id, 1);

    issue(0, 64'd9, 64'd0, 3'd6, 4'd1);
    check("div0_fl", lr_fl, 4'b1000);
    check("div0_y", lr_y, 64'hFFFF_FFFF_FFFF_FFFF);
    check("div0_rem", lr_rem, 9);

    issue(0, 64'd17, 64'd5, 3'd6, 4'd2);
    check("div_y", lr_y, 3);
    check("div_rem", lr_rem, 2);
    check("div_fl", lr_fl, 4'b0000);

    issue(1, 64'hDEAD, 64'hBEEF, 3'd7, 4'd6);
    check("rsv_y", lr_y, 0);
    check("rsv_fl", lr_fl, 4'b0001);

    // Response back-pressure with req1 pending.
    resp_ready = 0;
    set_req(0, 1, 64'd100, 64'd23, 3'd0, 4'd5);
    step();
    check("bp_accept", hs_done, 1);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 1, 64'd40, 64'd2, 3'd0, 4'd7);
    repeat (6) step();
    resp_ready = 1;
    step();
    check("bp_resp_done", rsp_done, 1);
    step();
    check("bp_req1_next", hs_done, 1);
    set_req(1, 0, 0, 0, 0, 0);
    drain();

    // Reset during EXEC aborts the op.
    set_req(0, 1, 64'd77, 64'd1, 3'd0, 4'd12);
    step();
    check("rx_accept", hs_done, 1);
    set_req(0, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    check("rx_resp_valid", resp_valid, 0);
    check("rx_resp_y", resp_y, 0);
    check("rx_resp_tag", resp_tag, 0);
    check("rx_alu_a", alu_a, 0);
    check("rx_perf0", perf_cnt0, 0);
    check("rx_perf1", perf_cnt1, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (5) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        logic [63:0] a, b;
        a = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 40))
                                        : {$urandom, $urandom};
        b = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 7))
                                        : {$urandom, $urandom};
        set_req(n, 1'($urandom_range(0, 1)), a, b,
                3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    drain();

`ifdef ALU_ARB_PERF_EN
    check("perf0_end", perf_cnt0, mcnt[0]);
    check("perf1_end", perf_cnt1, mcnt[1]);
`else
    check("perf0_end", perf_cnt0, 0);
    check("perf1_end", perf_cnt1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
